fnd_scan_rx: RTL and testbench

Receiving end of the multiplexed seven-segment scan bus: the six active-low digit enables, the 7-bit segment bus and the decimal point. It samples the scan, waits out transitions, and demultiplexes each dwell into per-digit registers. It decodes each segment pattern back to BCD and rebuilds the 0~59 count from the two rightmost digits. It serves as the self-check monitor on the display path and as the capture front end for the board's display-loopback test.

---
 rtl/fnd_scan_rx.sv | 188 ++++++++++++++++++
 tb/tb_fnd_scan_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_rx.sv
// Seven-segment scan bus receiver: settles each digit dwell, captures it into per-slot
// registers, decodes to BCD, rebuilds the 0..59 count and flags illegal or stale scans.
module fnd_scan_rx #(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [41:0] o_digit_seg,
   output logic [23:0] o_digits_bcd,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_digit_valid,
   output logic        o_frame_done,
   output logic [5:0]  o_count,
   output logic        o_count_valid,
   output logic        o_err,
   output logic        o_stale
);

   localparam int unsigned CW = $clog2(SETTLE + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [5:0]     s_enb, p_enb;
   logic [6:0]     s_seg, p_seg;
   logic           s_dp, p_dp;
   logic [5:0]     mask, mask_n;
   logic [TW-1:0]  timer;
   logic           is_idle, is_digit, same, capture, err;
   logic [2:0]     slot;
   logic [4:0]     dec;

   function automatic logic [4:0] fnd_dec(input logic [6:0] seg);
      case (seg)
         7'b1111110: return 5'h10;
         7'b0110000: return 5'h11;
         7'b1101101: return 5'h12;
         7'b1111001: return 5'h13;
         7'b0110011: return 5'h14;
         7'b1011011: return 5'h15;
         7'b1011111: return 5'h16;
         7'b1110000: return 5'h17;
         7'b1111111: return 5'h18;
         7'b1110011: return 5'h19;
         7'b0000000: return 5'h0F;
         default:    return 5'h0E;
      endcase
   endfunction

   // p_* holds the sample before s_*, so a dwell is measured as a run of equal samples
   always_ff @(posedge clk) begin
      if (rst) begin
         s_enb <= '1;
         s_seg <= '0;
         s_dp  <= 1'b0;
         p_enb <= '1;
         p_seg <= '0;
         p_dp  <= 1'b0;
      end else begin
         s_enb <= i_seg_enb;
         s_seg <= i_seg;
         s_dp  <= i_seg_dp;
         p_enb <= s_enb;
         p_seg <= s_seg;
         p_dp  <= s_dp;
      end
   end

   always_comb begin
      is_idle  = (s_enb == 6'h3F);
      is_digit = $onehot(~s_enb);
      same     = ({s_enb, s_seg, s_dp} == {p_enb, p_seg, p_dp});
      err      = !is_digit && !is_idle;
      dec      = fnd_dec(s_seg);
      slot     = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (!s_enb[i]) slot = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_WAIT;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      if (!is_digit) begin
         state_n = S_WAIT;
         cnt_n   = '0;
      end else begin
         case (state)
            S_WAIT: begin
               state_n = S_SETTLE;
               cnt_n   = CW'(1);
            end
            S_SETTLE: begin
               if (!same) begin
                  cnt_n = CW'(1);
               end else if (cnt == CW'(SETTLE - 1)) begin
                  capture = 1'b1;
                  state_n = S_HELD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_HELD: begin
               if (!same) begin
                  state_n = S_SETTLE;
                  cnt_n   = CW'(1);
               end
            end
            default: begin
               state_n = S_WAIT;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_comb begin
      mask_n = mask | (6'b1 << slot);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask          <= '0;
         timer         <= '0;
         o_digit_seg   <= '0;
         o_digits_bcd  <= '1;
         o_dp          <= '0;
         o_digit_valid <= '0;
         o_frame_done  <= 1'b0;
         o_count       <= '0;
         o_count_valid <= 1'b0;
         o_err         <= 1'b0;
         o_stale       <= 1'b0;
      end else begin
         o_err        <= err;
         o_frame_done <= 1'b0;
         // count uses the digit registers as they stood when the frame completed
         if (o_frame_done) begin
            if (o_digit_valid[1] && o_digit_valid[0] && (o_digits_bcd[7:4] <= 4'd5)) begin
               o_count       <= ({2'b0, o_digits_bcd[7:4]} << 3) + ({2'b0, o_digits_bcd[7:4]} << 1)
                                + {2'b0, o_digits_bcd[3:0]};
               o_count_valid <= 1'b1;
            end else begin
               o_count_valid <= 1'b0;
            end
         end
         if (capture) begin
            o_digit_seg[7*slot +: 7]  <= s_seg;
            o_dp[slot]                <= s_dp;
            o_digits_bcd[4*slot +: 4] <= dec[3:0];
            o_digit_valid[slot]       <= dec[4];
            timer                     <= '0;
            o_stale                   <= 1'b0;
            if (&mask_n) begin
               o_frame_done <= 1'b1;
               mask         <= '0;
            end else begin
               mask <= mask_n;
            end
         end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + 1'b1;
            if (timer == TW'(TIMEOUT - 1)) begin
               o_stale <= 1'b1;
               mask    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: directed scan scenarios plus random dwells, checked every cycle
// against a run-length model of the scan bus.
module tb_fnd_scan_rx;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 64;
   localparam logic [6:0] SEG3 = 7'b1111001;
   localparam logic [6:0] SEG7 = 7'b1110000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  enb;
   logic [6:0]  seg;
   logic        dp;
   logic [41:0] o_digit_seg;
   logic [23:0] o_digits_bcd;
   logic [5:0]  o_dp, o_digit_valid, o_count;
   logic        o_frame_done, o_count_valid, o_err, o_stale;

   fnd_scan_rx #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .i_seg_enb(enb), .i_seg(seg), .i_seg_dp(dp),
      .o_digit_seg(o_digit_seg), .o_digits_bcd(o_digits_bcd), .o_dp(o_dp),
      .o_digit_valid(o_digit_valid), .o_frame_done(o_frame_done), .o_count(o_count),
      .o_count_valid(o_count_valid), .o_err(o_err), .o_stale(o_stale)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_frames = 0;
   int n_errp   = 0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

   // reference state
   logic [41:0] m_digit_seg;
   logic [23:0] m_bcd;
   logic [5:0]  m_dp, m_valid, m_mask, m_count;
   logic        m_done, m_cval, m_err, m_stale;
   int          m_since;
   logic [13:0] prev_v, pend_v;
   int          run, pend_run;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] ref_dec(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (pat[i] == s) return {1'b1, 4'(i)};
      if (s == 7'd0) return 5'h0F;
      return 5'h0E;
   endfunction

   // Effects of the sample registered one edge earlier become visible at this edge.
   task automatic model_edge(input logic r, input logic [13:0] v);
      logic [5:0] e;
      logic [4:0] d;
      int k;
      if (r) begin
         m_digit_seg = '0; m_bcd = '1; m_dp = '0; m_valid = '0; m_mask = '0;
         m_done = 0; m_count = '0; m_cval = 0; m_err = 0; m_stale = 0; m_since = 0;
         prev_v = {6'h3F, 8'h00}; pend_v = prev_v; run = 1; pend_run = 1;
         return;
      end
      e = pend_v[13:8];
      m_err = ($countones(e) != 5) && (e != 6'h3F);
      if (m_done) begin
         if (m_valid[1] && m_valid[0] && m_bcd[7:4] <= 5) begin
            m_count = 6'(m_bcd[7:4] * 10 + m_bcd[3:0]);
            m_cval  = 1;
         end else begin
            m_cval = 0;
         end
      end
      m_done = 0;
      if ($countones(e) == 5 && pend_run == SETTLE) begin
         k = 0;
         for (int i = 0; i < 6; i++) if (!e[i]) k = i;
         d = ref_dec(pend_v[7:1]);
         m_digit_seg[k*7 +: 7] = pend_v[7:1];
         m_dp[k] = pend_v[0];
         m_bcd[k*4 +: 4] = d[3:0];
         m_valid[k] = d[4];
         m_mask[k] = 1'b1;
         if (m_mask == 6'h3F) begin
            m_done = 1;
            m_mask = '0;
         end
         m_since = 0;
         m_stale = 0;
      end else if (m_since < TIMEOUT) begin
         m_since++;
         if (m_since == TIMEOUT) begin
            m_stale = 1;
            m_mask  = '0;
         end
      end
      run = (v == prev_v) ? run + 1 : 1;
      prev_v = v;
      pend_v = v;
      pend_run = run;
   endtask

   task automatic check_all();
      check("digit_seg", 64'(o_digit_seg), 64'(m_digit_seg));
      check("bcd", 64'(o_digits_bcd), 64'(m_bcd));
      check("dp", 64'(o_dp), 64'(m_dp));
      check("valid", 64'(o_digit_valid), 64'(m_valid));
      check("frame_done", 64'(o_frame_done), 64'(m_done));
      check("count", 64'(o_count), 64'(m_count));
      check("count_valid", 64'(o_count_valid), 64'(m_cval));
      check("err", 64'(o_err), 64'(m_err));
      check("stale", 64'(o_stale), 64'(m_stale));
      if (o_frame_done) n_frames++;
      if (o_err) n_errp++;
   endtask

   task automatic step(input logic [5:0] e, input logic [6:0] s, input logic d);
      enb = e; seg = s; dp = d;
      @(posedge clk);
      model_edge(rst, {e, s, d});
      @(negedge clk);
      check_all();
   endtask

   task automatic dwell(input int k, input logic [6:0] s, input logic d, input int n);
      logic [5:0] e;
      e = ~(6'b1 << k);
      repeat (n) step(e, s, d);
   endtask

   task automatic gap(input int n);
      repeat (n) step(6'h3F, 7'd0, 1'b0);
   endtask

   task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input int len2);
      for (int k = 0; k < 6; k++) begin
         dwell(k, (k == 0) ? s0 : (k == 1) ? s1 : 7'd0, 1'b0, (k == 2) ? len2 : 10);
         gap(1);
      end
   endtask

   initial begin
      int f0, e0;
      logic [5:0] cnt_saved;
      logic [6:0] rs;
      rst = 1'b1; enb = 6'h3F; seg = '0; dp = 1'b0;
      @(negedge clk);
      gap(2);
      rst = 1'b0;
      check("reset_bcd", 64'(o_digits_bcd), 64'h00FFFFFF);
      check("reset_valid", 64'(o_digit_valid), 64'h0);

      // 1: plain "37" frame
      f0 = n_frames;
      scan(SEG7, SEG3, 10);
      gap(2);
      check("s1_frames", 64'(n_frames - f0), 64'd1);
      check("s1_bcd", 64'(o_digits_bcd), 64'h00FFFF37);
      check("s1_valid", 64'(o_digit_valid), 64'h03);
      check("s1_count", 64'(o_count), 64'd37);
      check("s1_count_valid", 64'(o_count_valid), 64'd1);

      // 2: short dwell on digit 2 does not capture
      f0 = n_frames;
      scan(SEG7, SEG3, 3);
      gap(3);
      check("s2_no_frame", 64'(n_frames - f0), 64'd0);
      dwell(2, 7'd0, 1'b0, 4);
      gap(2);
      check("s2_frame", 64'(n_frames - f0), 64'd1);

      // 3: illegal enables mid-dwell
      e0 = n_errp;
      dwell(1, SEG3, 1'b1, 3);
      step(6'b111100, SEG3, 1'b1);
      step(6'b111100, SEG3, 1'b1);
      dwell(1, SEG3, 1'b1, 10);
      gap(1);
      check("s3_err_cycles", 64'(n_errp - e0), 64'd2);

      // 4: undecodable slot 0
      cnt_saved = o_count;
      scan(7'b1000001, SEG3, 10);
      gap(2);
      check("s4_nibble0", 64'(o_digits_bcd[3:0]), 64'hE);
      check("s4_valid0", 64'(o_digit_valid[0]), 64'd0);
      check("s4_count_valid", 64'(o_count_valid), 64'd0);
      check("s4_count_held", 64'(o_count), 64'(cnt_saved));

      // 5: stale scan
      gap(70);
      check("s5_stale", 64'(o_stale), 64'd1);
      dwell(0, SEG7, 1'b0, 4);
      gap(1);
      check("s5_stale_clear", 64'(o_stale), 64'd0);

      // 6: reset mid-frame
      dwell(0, SEG7, 1'b0, 5); dwell(1, SEG3, 1'b0, 5); dwell(2, 7'd0, 1'b0, 5);
      rst = 1'b1;
      step(6'b111011, 7'd0, 1'b0);
      rst = 1'b0;
      check("s6_bcd", 64'(o_digits_bcd), 64'h00FFFFFF);
      check("s6_seg", 64'(o_digit_seg), 64'h0);
      f0 = n_frames;
      scan(SEG7, SEG3, 10);
      gap(2);
      check("s6_frame", 64'(n_frames - f0), 64'd1);

      // random dwells
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: rs = 7'd0;
            1: rs = 7'($urandom);
            default: rs = pat[$urandom_range(0, 9)];
         endcase
         dwell($urandom_range(0, 5), rs, 1'($urandom), $urandom_range(1, 9));
         if ($urandom_range(0, 19) == 0) step(6'($urandom), 7'($urandom), 1'b0);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1; gap(1); rst = 1'b0;
         end
         gap($urandom_range(0, 2));
      end
      gap(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
